ps2_key_event_ctrl: RTL and testbench

PS2_KEY_EVENT_CTRL -- requirements
Module: ps2_key_event_ctrl

---
 rtl/ps2_key_event_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_ps2_key_event_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_event_ctrl.sv
// ps2_key_event_ctrl - PS/2 set-2 scan-code decoder with an event FIFO.
//
// Turns the raw PS/2 byte stream into key events {code, ext, break}. The
// E0 (extended) and F0 (release) prefixes are folded into flags. The E1 Pause
// sequence becomes a single event. Events are queued in a show-ahead FIFO.
//
// Parameters
//   FIFO_DEPTH     event FIFO entries (power of two, 2..32)
//   TIMEOUT_CYCLES idle cycles before a partial prefix sequence is abandoned
//
// Ports
//   clk, rst              system clock, synchronous active-high reset
//   rx_byte/valid/err     received byte, its strobe, frame error strobe
//   evt_code/ext/break    FIFO head fields (read 0 while empty)
//   evt_valid, evt_ready  FIFO non-empty / consumer accept
//   clr_ovf, ovf          sticky overflow flag and its clear
//   err_cnt               saturating count of rx_err strobes
//
// Optional feature: define PS2_REPEAT_FILTER_EN to drop typematic repeat makes
// of a key that is already held.
module ps2_key_event_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_valid,
  input  logic       rx_err,
  output logic [7:0] evt_code,
  output logic       evt_ext,
  output logic       evt_break,
  output logic       evt_valid,
  input  logic       evt_ready,
  input  logic       clr_ovf,
  output logic       ovf,
  output logic [7:0] err_cnt
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] DepthC = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {StIdle, StGotE0, StGotF0, StGotE0F0, StSkipPause} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q;
  logic [2:0]    skip_q, skip_d;
  logic [7:0]    err_cnt_q;

  logic       cand_push, cand_ext, cand_brk, cand_pause;
  logic       filt_drop, push, pop, wr_en, full;
  logic       ovf_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] cnt_q;
  logic [9:0]    mem_q [FIFO_DEPTH];
  logic [9:0]    head;

  // Byte decode: next state and the candidate event for this strobe.
  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    cand_push  = 1'b0;
    cand_ext   = 1'b0;
    cand_brk   = 1'b0;
    cand_pause = 1'b0;
    if (rx_valid) begin
      case (state_q)
        StIdle: begin
          if (rx_byte == 8'hE0) begin
            state_d = StGotE0;
          end else if (rx_byte == 8'hF0) begin
            state_d = StGotF0;
          end else if (rx_byte == 8'hE1) begin
            cand_push  = 1'b1;
            cand_pause = 1'b1;
            skip_d     = 3'd0;
            state_d    = StSkipPause;
          end else if (!(rx_byte inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
            cand_push = 1'b1;
          end
        end
        StGotE0: begin
          state_d = StIdle;
          if (rx_byte == 8'hF0) begin
            state_d = StGotE0F0;
          end else if (rx_byte != 8'hE0) begin
            cand_push = 1'b1;
            cand_ext  = 1'b1;
          end
        end
        StGotF0, StGotE0F0: begin
          state_d = StIdle;
          if (rx_byte != 8'hE0 && rx_byte != 8'hF0) begin
            cand_push = 1'b1;
            cand_brk  = 1'b1;
            cand_ext  = (state_q == StGotE0F0);
          end
        end
        StSkipPause: begin
          // The 7 trailing Pause bytes are swallowed; the 7th returns to idle.
          if (skip_q == 3'd6) begin
            skip_d  = 3'd0;
            state_d = StIdle;
          end else begin
            skip_d = skip_q + 3'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      skip_q  <= '0;
    end else if (rx_err) begin
      state_q <= StIdle;
      tmo_q   <= '0;
      skip_q  <= '0;
    end else if (rx_valid) begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= '0;
    end else if (state_q != StIdle) begin
      if (tmo_q == TmoLast) begin
        state_q <= StIdle;
        skip_q  <= '0;
        tmo_q   <= '0;
      end else begin
        tmo_q <= tmo_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (rx_err && err_cnt_q != 8'hFF) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

`ifdef PS2_REPEAT_FILTER_EN
  logic [255:0] held_q;
  logic [7:0]   held_idx;

  // The Pause event has no release, so it bypasses the held table.
  always_comb begin
    held_idx  = {cand_ext, rx_byte[6:0]};
    filt_drop = cand_push && !cand_pause && !cand_brk && held_q[held_idx];
  end

  always_ff @(posedge clk) begin
    if (rst || rx_err) begin
      held_q <= '0;
    end else if (cand_push && !cand_pause) begin
      held_q[held_idx] <= !cand_brk;
    end
  end
`else
  assign filt_drop = 1'b0;
`endif

  assign push  = cand_push && !rx_err && !filt_drop;
  assign full  = (cnt_q == DepthC);
  assign pop   = evt_valid && evt_ready;
  // A pop frees the slot the push needs, so push-at-full with pop is legal.
  assign wr_en = push && (!full || pop);

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_ptr_q] <= {cand_ext, cand_brk, rx_byte};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      if (wr_en && !pop)      cnt_q <= cnt_q + CW'(1);
      else if (pop && !wr_en) cnt_q <= cnt_q - CW'(1);
      // Set wins over a coincident clear.
      if (push && full && !pop) ovf_q <= 1'b1;
      else if (clr_ovf)         ovf_q <= 1'b0;
    end
  end

  assign evt_valid = (cnt_q != '0);
  assign head      = evt_valid ? mem_q[rd_ptr_q] : 10'd0;
  assign evt_code  = head[7:0];
  assign evt_break = head[8];
  assign evt_ext   = head[9];
  assign ovf       = ovf_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_ps2_key_event_ctrl.sv
module tb_ps2_key_event_ctrl;

  localparam int unsigned Tmo = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;
  logic [7:0] evt_code;
  logic       evt_ext, evt_break, evt_valid;
  logic       evt_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       ovf;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  ps2_key_event_ctrl #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(Tmo)) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_err),
    .evt_code (evt_code),
    .evt_ext  (evt_ext),
    .evt_break(evt_break),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .clr_ovf  (clr_ovf),
    .ovf      (ovf),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  // Head as {valid, ext, break, code}.
  wire [10:0] head = {evt_valid, evt_ext, evt_break, evt_code};

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic pulse_err(input logic with_valid, input logic [7:0] b);
    @(negedge clk);
    rx_byte  = b;
    rx_valid = with_valid;
    rx_err   = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_err   = 1'b0;
  endtask

  task automatic pop1();
    @(negedge clk);
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (head !== 11'h000) begin
      n_fail++; $display("FAIL reset_head: got %h want 000", head);
    end
    n_checks++;
    if ({ovf, err_cnt} !== 9'h000) begin
      n_fail++; $display("FAIL reset_flags: ovf=%b err_cnt=%0d want 0/0", ovf, err_cnt);
    end
  endtask

  task automatic test_make_break();
    do_reset();
    send(8'h1C);
    n_checks++;
    if (head !== {3'b100, 8'h1C}) begin
      n_fail++; $display("FAIL make_latency: got %h want 41c", head);
    end
    send(8'hF0);
    send(8'h1C);
    pop1();
    n_checks++;
    if (head !== {3'b101, 8'h1C}) begin
      n_fail++; $display("FAIL break_event: got %h want 51c", head);
    end
    pop1();
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL make_break_empty: evt_valid=%b want 0", evt_valid);
    end
  endtask

  task automatic test_ext_timeout();
    do_reset();
    send(8'hE0); send(8'hF0); send(8'h75);
    n_checks++;
    if (head !== {3'b111, 8'h75}) begin
      n_fail++; $display("FAIL ext_break: got %h want 775", head);
    end
    pop1();
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL ext_break_single: evt_valid=%b want 0", evt_valid);
    end
    // Just under the timeout the prefix still applies.
    send(8'hE0);
    idle(Tmo - 10);
    send(8'h75);
    n_checks++;
    if (head !== {3'b110, 8'h75}) begin
      n_fail++; $display("FAIL ext_before_timeout: got %h want 675", head);
    end
    pop1();
    send(8'hE0);
    idle(2 * Tmo);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL timeout_no_event: evt_valid=%b want 0", evt_valid);
    end
    send(8'h75);
    n_checks++;
    if (head !== {3'b100, 8'h75}) begin
      n_fail++; $display("FAIL after_timeout: got %h want 475", head);
    end
    pop1();
  endtask

  task automatic test_discard();
    logic [7:0] noise [6] = '{8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};
    do_reset();
    for (int i = 0; i < 6; i++) send(noise[i]);
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL noise_discard: evt_valid=%b want 0", evt_valid);
    end
    // A second E0 aborts the prefix, so 1C decodes from idle.
    send(8'hE0); send(8'hE0); send(8'h1C);
    n_checks++;
    if (head !== {3'b100, 8'h1C}) begin
      n_fail++; $display("FAIL illegal_prefix_abort: got %h want 41c", head);
    end
    pop1();
  endtask

  task automatic test_overflow();
    logic [7:0] exp;
    do_reset();
    for (int i = 0; i < 9; i++) send(8'(8'h10 + i));
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: ovf=%b want 1", ovf);
    end
    @(negedge clk); clr_ovf = 1'b1;
    @(negedge clk); clr_ovf = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clear: ovf=%b want 0", ovf);
    end
    // Pop and push together at full.
    @(negedge clk);
    rx_byte = 8'h20; rx_valid = 1'b1; evt_ready = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; evt_ready = 1'b0;
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++; $display("FAIL full_pop_push_ovf: ovf=%b want 0", ovf);
    end
    // Overflow set and clear in the same cycle: set wins.
    @(negedge clk);
    rx_byte = 8'h21; rx_valid = 1'b1; clr_ovf = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; clr_ovf = 1'b0;
    n_checks++;
    if (ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set_over_clear: ovf=%b want 1", ovf);
    end
    for (int i = 0; i < 8; i++) begin
      exp = (i < 7) ? 8'(8'h11 + i) : 8'h20;
      n_checks++;
      if (head !== {3'b100, exp}) begin
        n_fail++; $display("FAIL drain_%0d: got %h want %h", i, head, {3'b100, exp});
      end
      pop1();
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL drain_empty: evt_valid=%b want 0", evt_valid);
    end
  endtask

  task automatic test_pause();
    logic [7:0] seq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
    do_reset();
    for (int i = 0; i < 9; i++) send(seq[i]);
    n_checks++;
    if (head !== {3'b100, 8'hE1}) begin
      n_fail++; $display("FAIL pause_event: got %h want 4e1", head);
    end
    pop1();
    n_checks++;
    if (head !== {3'b100, 8'h1C}) begin
      n_fail++; $display("FAIL after_pause: got %h want 41c", head);
    end
    pop1();
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL pause_only_two: evt_valid=%b want 0", evt_valid);
    end
  endtask

  task automatic test_err();
    do_reset();
    send(8'hF0);
    pulse_err(1'b0, 8'h00);
    send(8'h1C);
    n_checks++;
    if ({err_cnt, head} !== {8'd1, 3'b100, 8'h1C}) begin
      n_fail++; $display("FAIL err_abort: err_cnt=%0d head=%h want 1/41c", err_cnt, head);
    end
    pop1();
    pulse_err(1'b1, 8'h1C);
    n_checks++;
    if ({err_cnt, evt_valid} !== {8'd2, 1'b0}) begin
      n_fail++; $display("FAIL err_priority: err_cnt=%0d valid=%b want 2/0", err_cnt, evt_valid);
    end
    for (int i = 0; i < 300; i++) pulse_err(1'b0, 8'h00);
    n_checks++;
    if (err_cnt !== 8'd255) begin
      n_fail++; $display("FAIL err_saturate: err_cnt=%0d want 255", err_cnt);
    end
    do_reset();
    n_checks++;
    if (err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL err_reset: err_cnt=%0d want 0", err_cnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(8'h1C);
    send(8'hE0);
    do_reset();
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_flush: evt_valid=%b want 0", evt_valid);
    end
    send(8'h75);
    n_checks++;
    if (head !== {3'b100, 8'h75}) begin
      n_fail++; $display("FAIL reset_decode_idle: got %h want 475", head);
    end
    pop1();
  endtask

  task automatic test_repeat();
    logic [7:0] seq [6] = '{8'h1C, 8'h1C, 8'h1C, 8'hF0, 8'h1C, 8'h1C};
    logic [10:0] exp [5];
    int n_exp;
`ifdef PS2_REPEAT_FILTER_EN
    exp   = '{11'h41C, 11'h51C, 11'h41C, 11'h000, 11'h000};
    n_exp = 3;
`else
    exp   = '{11'h41C, 11'h41C, 11'h41C, 11'h51C, 11'h41C};
    n_exp = 5;
`endif
    do_reset();
    for (int i = 0; i < 6; i++) send(seq[i]);
    for (int i = 0; i < n_exp; i++) begin
      n_checks++;
      if (head !== exp[i]) begin
        n_fail++; $display("FAIL repeat_%0d: got %h want %h", i, head, exp[i]);
      end
      pop1();
    end
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL repeat_count: evt_valid=%b want 0", evt_valid);
    end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_ext_timeout();
    test_discard();
    test_overflow();
    test_pause();
    test_err();
    test_reset_mid();
    test_repeat();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
